// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state debounce FSM,
// registered level/edge outputs and an 8-bit wrapping press counter.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_out,
    output logic       key_press,
    output logic       key_release,
    output logic [7:0] press_cnt
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    logic          sync1;
    logic          sync2;
    logic          key_sync;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;
    logic          release_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign key_sync = sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (key_sync) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!key_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_sync) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                // A bounce back to 1 returns to PRESSED silently.
                if (key_sync) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the FSM transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out     <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            press_cnt   <= '0;
        end else begin
            key_out     <= (state_nxt == PRESSED) || (state_nxt == WAIT_RELEASE);
            key_press   <= press_nxt;
            key_release <= release_nxt;
            if (press_nxt) begin
                press_cnt <= press_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce with DEBOUNCE_CYCLES=4.
module tb_key_debounce;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       key_out;
    logic       key_press;
    logic       key_release;
    logic [7:0] press_cnt;

    int checks = 0;
    int errors = 0;

    int press_pulses   = 0;
    int release_pulses = 0;
    int out_rises      = 0;
    int out_falls      = 0;
    int pulse_faults   = 0;
    logic prev_out     = 1'b0;
    logic prev_press   = 1'b0;
    logic prev_release = 1'b0;

    key_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .press_cnt  (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (key_press)   press_pulses++;
        if (key_release) release_pulses++;
        if (key_out && !prev_out) out_rises++;
        if (!key_out && prev_out) out_falls++;
        if (key_press && key_release) pulse_faults++;
        if (key_press && prev_press) pulse_faults++;
        if (key_release && prev_release) pulse_faults++;
        prev_out     = key_out;
        prev_press   = key_press;
        prev_release = key_release;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int p0, r0, f0, rise0;

    initial begin
        rst    = 1'b1;
        key_in = 1'b0;
        tick(3);
        check("rst_out",   key_out,     0);
        check("rst_press", key_press,   0);
        check("rst_rel",   key_release, 0);
        check("rst_cnt",   press_cnt,   0);
        rst = 1'b0;
        tick(2);

        // Clean press: sampled at edge 1, visible after edge 7.
        key_in = 1'b1;
        tick(6);
        check("press_early_out",   key_out,   0);
        check("press_early_pulse", key_press, 0);
        tick(1);
        check("press_out",   key_out,   1);
        check("press_pulse", key_press, 1);
        check("press_cnt1",  press_cnt, 1);
        tick(1);
        check("press_pulse_end", key_press, 0);
        check("press_out_hold",  key_out,   1);
        tick(12);

        // Clean release.
        key_in = 1'b0;
        tick(6);
        check("rel_early_out", key_out, 1);
        tick(1);
        check("rel_out",   key_out,     0);
        check("rel_pulse", key_release, 1);
        check("rel_cnt",   press_cnt,   1);
        tick(1);
        check("rel_pulse_end", key_release, 0);
        tick(4);

        // Three-sample glitch while idle.
        p0 = press_pulses;
        key_in = 1'b1;
        tick(3);
        key_in = 1'b0;
        tick(10);
        check("glitch_idle_out",    key_out,      0);
        check("glitch_idle_pulses", press_pulses, p0);
        check("glitch_idle_cnt",    press_cnt,    1);

        // Bouncing press.
        p0    = press_pulses;
        f0    = out_falls;
        rise0 = out_rises;
        key_in = 1'b1; tick(1);
        key_in = 1'b0; tick(1);
        key_in = 1'b1; tick(1);
        key_in = 1'b0; tick(1);
        key_in = 1'b1;
        tick(20);
        check("bounce_pulses", press_pulses - p0, 1);
        check("bounce_cnt",    press_cnt,         2);
        check("bounce_out",    key_out,           1);
        check("bounce_rises",  out_rises - rise0, 1);
        check("bounce_falls",  out_falls - f0,    0);

        // One-sample low glitch while pressed.
        r0 = release_pulses;
        key_in = 1'b0; tick(1);
        key_in = 1'b1;
        tick(10);
        check("glitch_pr_out",   key_out,             1);
        check("glitch_pr_rel",   release_pulses - r0, 0);
        check("glitch_pr_falls", out_falls - f0,      0);

        key_in = 1'b0;
        tick(10);
        check("rel2_out", key_out,   0);
        check("rel2_cnt", press_cnt, 2);

        // Wrap: 256 pairs bring the counter back to its start value.
        p0 = press_pulses;
        for (int i = 0; i < 256; i++) begin
            key_in = 1'b1; tick(8);
            key_in = 1'b0; tick(8);
            if (i == 252) check("wrap_255", press_cnt, 255);
            if (i == 253) check("wrap_0",   press_cnt, 0);
        end
        check("wrap_cnt",    press_cnt,         2);
        check("wrap_pulses", press_pulses - p0, 256);

        // Async reset mid-WAIT_PRESS, key held through reset.
        p0 = press_pulses;
        key_in = 1'b1;
        tick(4);
        #2 rst = 1'b1;
        #1;
        check("arst_out",    key_out,   0);
        check("arst_press",  key_press, 0);
        check("arst_cnt",    press_cnt, 0);
        tick(2);
        check("arst_pulses", press_pulses - p0, 0);
        rst = 1'b0;
        tick(6);
        check("arst_early_out", key_out, 0);
        tick(1);
        check("arst_out_set", key_out,   1);
        check("arst_press_p", key_press, 1);
        check("arst_cnt1",    press_cnt, 1);
        tick(2);

        check("pulse_rules", pulse_faults, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 20, meaning the number of consecutive synchronized samples required to accept a level change (legal range 2..2^24; board builds override to 1_000_000 at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port key_in, input, 1 bit: raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-005 The block SHALL have port key_out, output, 1 bit: debounced, registered key level, suitable to drive a downstream D flip-flop stage directly.
REQ-006 The block SHALL have port key_press, output, 1 bit: one-cycle pulse when key_out rises.
REQ-007 The block SHALL have port key_release, output, 1 bit: one-cycle pulse when key_out falls.
REQ-008 The block SHALL have port press_cnt, output, 8 bits: count of accepted presses.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer (sync1, sync2); key_sync = sync2; no other logic SHALL sample key_in.
REQ-010 The debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-011 The FSM SHALL have four states: IDLE (stable 0), WAIT_PRESS, PRESSED (stable 1), WAIT_RELEASE.
REQ-012 IDLE: key_sync=1 -> WAIT_PRESS with cnt=0; otherwise hold.
REQ-013 WAIT_PRESS: key_sync=0 -> IDLE with cnt=0; key_sync=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; else cnt+1.
REQ-014 PRESSED: key_sync=0 -> WAIT_RELEASE with cnt=0; otherwise hold.
REQ-015 WAIT_RELEASE: key_sync=1 -> PRESSED with cnt=0 and no pulse; key_sync=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-016 key_out SHALL be registered, 1 exactly in PRESSED and WAIT_RELEASE.
REQ-017 key_press SHALL be registered, 1 for exactly the cycle following the WAIT_PRESS->PRESSED edge; key_release likewise for WAIT_RELEASE->IDLE.
REQ-018 key_press and key_release SHALL never be 1 in the same cycle, nor either high for two consecutive cycles.
REQ-019 Latency: a clean 0->1 step on key_in first sampled at edge k SHALL set key_out=1 and key_press=1 after edge k+2+DEBOUNCE_CYCLES; the release path SHALL be symmetric.
REQ-020 Any key_sync excursion shorter than DEBOUNCE_CYCLES+1 consecutive samples SHALL leave key_out, key_press, key_release and press_cnt unchanged.
REQ-021 press_cnt SHALL increment by 1 in the same edge that sets key_press, wrapping 255 -> 0 without saturation or flag.

Reset
REQ-022 While rst=1, independent of clk: sync1=sync2=0, state=IDLE, cnt=0, key_out=0, key_press=0, key_release=0, press_cnt=0.
REQ-023 Reset asserted mid-debounce or mid-press SHALL abort with no pulse generated; after release the block SHALL treat a held key as a new press requiring full debounce.
REQ-024 Deassertion SHALL be the only event that re-enables state updates; first update at the next rising clk edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Clean press: key_in 0->1 held 20 cycles -> key_out=1 and key_press=1 after the 7th edge, key_press=0 next cycle, press_cnt=1.
REQ-026 Bounce: key_in toggles 1,0,1,0 every cycle then holds 1 -> exactly one key_press, press_cnt=1, key_out never toggles back.
REQ-027 Glitch: key_in=1 for 3 cycles while IDLE -> no change on any output; 1-cycle 0 glitch while PRESSED -> key_out stays 1, no key_release.
REQ-028 Release: held key released cleanly -> key_out=0 and one key_release pulse after 7 edges; press_cnt unchanged.
REQ-029 Wrap: 256 clean press/release pairs -> press_cnt returns to 0, exactly 256 key_press pulses.
REQ-030 Async reset: rst pulsed mid-WAIT_PRESS between clk edges -> all outputs 0 immediately; key held through reset -> key_press after full 7-edge latency from deassertion.
